// File: rtl/sort_pkg.sv
// Shared definitions for the byte sorter and its result serializer.
//   SORT_N / SORT_W : default frame geometry (bytes per frame, bits per byte)
//   sort_byte_t     : one sorted byte
//   sort_frame_t    : one full frame, index 0 first
//   state_t         : serializer FSM states
package sort_pkg;
    localparam int SORT_N = 6;
    localparam int SORT_W = 8;

    typedef logic [SORT_W-1:0] sort_byte_t;
    typedef sort_byte_t sort_frame_t [0:SORT_N-1];

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/sort_result_serializer_if.sv
// Serial result stream between the serializer (master) and the result port
// (slave).
//   out_data  : current byte
//   out_valid : out_data valid
//   out_ready : slave accepts when out_valid && out_ready
//   out_last  : marks the final byte of a frame
//   out_index : position of out_data inside its frame
interface sort_result_serializer_if #(
    parameter int SORT_N = sort_pkg::SORT_N,
    parameter int SORT_W = sort_pkg::SORT_W
);
    localparam int IDX_W = (SORT_N > 1) ? $clog2(SORT_N) : 1;

    logic [SORT_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IDX_W-1:0]  out_index;

    modport master (
        output out_data, out_valid, out_last, out_index,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last, out_index,
        output out_ready
    );
endinterface

// File: rtl/sort_result_serializer.sv
// Captures one sorted frame on a single-cycle frame_valid and streams it out
// byte by byte, index 0 first, over a valid/ready handshake.
//   clk, reset   : clock, asynchronous active-high reset
//   frame_data   : parallel sorted frame from the sorter
//   frame_valid  : one-cycle qualifier for frame_data
//   out          : serial stream (master side)
//   busy         : a frame is held and not fully drained
//   overrun      : sticky, a frame arrived while busy and was dropped
//   overrun_clr  : synchronous clear of overrun
module sort_result_serializer #(
    parameter int SORT_N = sort_pkg::SORT_N,
    parameter int SORT_W = sort_pkg::SORT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SORT_W-1:0]          frame_data [0:SORT_N-1],
    input  logic                       frame_valid,
    sort_result_serializer_if.master   out,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       overrun_clr
);
    import sort_pkg::*;

    localparam int IDX_W = (SORT_N > 1) ? $clog2(SORT_N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SORT_N - 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic [SORT_W-1:0] buf_q [0:SORT_N-1];

    logic accept, last_accept, load, drop;

    assign accept      = (state == SEND) && out.out_ready;
    assign last_accept = accept && (idx == IDX_LAST);
    // A new frame is taken when idle, or exactly on the final-byte accept so
    // consecutive frames stream without a bubble. Anything else while busy is lost.
    assign load        = frame_valid && ((state == IDLE) || last_accept);
    assign drop        = frame_valid && !load;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (frame_valid)                 state_nx = SEND;
            SEND: if (last_accept && !frame_valid) state_nx = IDLE;
            default:                               state_nx = IDLE;
        endcase
    end

    // frame buffer and byte index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            for (int i = 0; i < SORT_N; i++) buf_q[i] <= '0;
        end else if (load) begin
            idx <= '0;
            for (int i = 0; i < SORT_N; i++) buf_q[i] <= frame_data[i];
        end else if (last_accept) begin
            idx <= '0;                   // frame done, park at 0
        end else if (accept) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // sticky overrun; a fresh drop wins over a clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

    // outputs, decoded purely from registered state so they settle right after the edge
    always_comb begin
        out.out_valid = (state == SEND);
        out.out_data  = '0;
        out.out_last  = 1'b0;
        out.out_index = idx;
        busy          = (state == SEND);
        if (state == SEND) begin
            out.out_data = buf_q[idx];
            out.out_last = (idx == IDX_LAST);
        end
    end
endmodule
